// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for a classic multi-cycle MIPS-style datapath. It walks
//   FETCH -> DECODE -> (execute/memory/write-back) -> FETCH. It drives the
//   memory strobes, the PC/IR write enables and the datapath mux selects
//   for each step.
//
//   Optional feature:
//     MULTICYCLE_CTRL_JUMP_EN  - when defined, opcode 2 (J) is decoded into a
//                                one-cycle JUMP state. When undefined,
//                                opcode 2 is treated as illegal.
//
// Parameters
//   ALUOP_W  width of alu_op_o (must be >= 3)
//   OP_W     width of the opcode and funct fields
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active low
//   instr_op_i       opcode field of the instruction register
//   instr_funct_i    funct field of the instruction register
//   mem_ready_i      memory completes the current access this cycle
//   pc_write_o       unconditional PC write
//   pc_write_cond_o  PC write qualified by ALU zero (branch)
//   ir_write_o       instruction register load
//   mem_read_o       memory read strobe
//   mem_write_o      memory write strobe
//   iord_o           memory address select (0=PC, 1=ALUOut)
//   reg_write_o      register file write enable
//   reg_dst_o        destination register select (0=rt, 1=rd)
//   mem_to_reg_o     write-back data select (0=ALUOut, 1=MDR)
//   alu_src_a_o      ALU A select (0=PC, 1=regA)
//   alu_src_b_o      ALU B select (0=regB, 1=4, 2=imm, 3=imm<<2)
//   pc_src_o         PC source (0=ALU, 1=ALUOut, 2=jump target)
//   alu_op_o         ALU operation (0=add, 1=sub, 2=funct, 3=slt)
//   illegal_o        one-cycle pulse on an unsupported opcode
//   state_o          current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned OP_W    = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic [OP_W-1:0]    instr_funct_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               ir_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               iord_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         pc_src_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               illegal_o,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    RWB    = 4'd7,
    EXEC_I = 4'd8,
    IWB    = 4'd9,
`ifdef MULTICYCLE_CTRL_JUMP_EN
    JUMP   = 4'd11,
`endif
    BRANCH = 4'd10
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
`endif

  state_e     state_q, state_d;
  logic [1:0] alu_op;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = FETCH;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'd0;
    pc_src_o        = 2'd0;
    alu_op          = 2'd0;
    illegal_o       = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        if (mem_ready_i) begin
          // Reset forces FETCH asynchronously; the Mealy strobes must stay
          // low for as long as reset is held.
          ir_write_o = rst_i;
          pc_write_o = rst_i;
          state_d    = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        alu_src_b_o = 2'd3;
        if (instr_op_i == OP_RTYPE) begin
          state_d = (instr_funct_i != '0) ? EXEC_R : FETCH;
        end else if (instr_op_i == OP_ADDI || instr_op_i == OP_SLTI) begin
          state_d = EXEC_I;
        end else if (instr_op_i == OP_LW || instr_op_i == OP_SW) begin
          state_d = MEMADR;
        end else if (instr_op_i == OP_BEQ) begin
          state_d = BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
        end else if (instr_op_i == OP_J) begin
          state_d = JUMP;
`endif
        end else begin
          illegal_o = 1'b1;
          state_d   = FETCH;
        end
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        state_d     = (instr_op_i == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        state_d    = mem_ready_i ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        state_d     = mem_ready_i ? FETCH : MEMWR;
      end
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op      = 2'd2;
        state_d     = RWB;
      end
      RWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_d     = FETCH;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op      = (instr_op_i == OP_SLTI) ? 2'd3 : 2'd0;
        state_d     = IWB;
      end
      IWB: begin
        reg_write_o = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op          = 2'd1;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'd1;
        state_d         = FETCH;
      end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'd2;
        state_d    = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  assign alu_op_o = {{(ALUOP_W-2){1'b0}}, alu_op};
  assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] instr_op_i = '0;
  logic [5:0] instr_funct_i = '0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o;
  logic       iord_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [2:0] alu_op_o;
  logic       illegal_o;
  logic [3:0] state_o;

  multicycle_ctrl #(.ALUOP_W(3), .OP_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_op_i(instr_op_i), .instr_funct_i(instr_funct_i),
    .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .ir_write_o(ir_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .iord_o(iord_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       rdy;
    logic [3:0] st;
    outs_t      o;
  } vec_t;

  vec_t  vq[$];
  int    checks = 0;
  int    errors = 0;

  outs_t O_FW, O_FR, O_DEC, O_DECI, O_MADR, O_MRD, O_MWB, O_MWR;
  outs_t O_EXR, O_RWB, O_EXI_ADD, O_EXI_SLT, O_IWB, O_BR, O_J;

  function automatic outs_t get_act();
    outs_t a;
    a.pc_write      = pc_write_o;
    a.pc_write_cond = pc_write_cond_o;
    a.ir_write      = ir_write_o;
    a.mem_read      = mem_read_o;
    a.mem_write     = mem_write_o;
    a.iord          = iord_o;
    a.reg_write     = reg_write_o;
    a.reg_dst       = reg_dst_o;
    a.mem_to_reg    = mem_to_reg_o;
    a.alu_src_a     = alu_src_a_o;
    a.alu_src_b     = alu_src_b_o;
    a.pc_src        = pc_src_o;
    a.alu_op        = alu_op_o;
    a.illegal       = illegal_o;
    return a;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic rst, input int op, input int funct,
                     input logic rdy, input int st, input outs_t o);
    vec_t v;
    v.rst = rst; v.op = 6'(op); v.funct = 6'(funct); v.rdy = rdy;
    v.st = 4'(st); v.o = o;
    vq.push_back(v);
  endtask

  initial begin
    O_FW = '0; O_FW.mem_read = 1; O_FW.alu_src_b = 2'd1;
    O_FR = O_FW; O_FR.ir_write = 1; O_FR.pc_write = 1;
    O_DEC = '0; O_DEC.alu_src_b = 2'd3;
    O_DECI = O_DEC; O_DECI.illegal = 1;
    O_MADR = '0; O_MADR.alu_src_a = 1; O_MADR.alu_src_b = 2'd2;
    O_MRD = '0; O_MRD.mem_read = 1; O_MRD.iord = 1;
    O_MWB = '0; O_MWB.reg_write = 1; O_MWB.mem_to_reg = 1;
    O_MWR = '0; O_MWR.mem_write = 1; O_MWR.iord = 1;
    O_EXR = '0; O_EXR.alu_src_a = 1; O_EXR.alu_op = 3'd2;
    O_RWB = '0; O_RWB.reg_write = 1; O_RWB.reg_dst = 1;
    O_EXI_ADD = '0; O_EXI_ADD.alu_src_a = 1; O_EXI_ADD.alu_src_b = 2'd2;
    O_EXI_SLT = O_EXI_ADD; O_EXI_SLT.alu_op = 3'd3;
    O_IWB = '0; O_IWB.reg_write = 1;
    O_BR = '0; O_BR.alu_src_a = 1; O_BR.alu_op = 3'd1;
    O_BR.pc_write_cond = 1; O_BR.pc_src = 2'd1;
    O_J = '0; O_J.pc_write = 1; O_J.pc_src = 2'd2;

    // reset held: FETCH Moore values, strobes gated even with ready high
    add(0, 0, 0, 1, 0, O_FW);
    // ADD
    add(1, 0, 32, 1, 0, O_FR);
    add(1, 0, 32, 1, 1, O_DEC);
    add(1, 0, 32, 1, 6, O_EXR);
    add(1, 0, 32, 1, 7, O_RWB);
    // LW with a fetch stall and three MEMRD stall cycles
    add(1, 35, 0, 0, 0, O_FW);
    add(1, 35, 0, 1, 0, O_FR);
    add(1, 35, 0, 1, 1, O_DEC);
    add(1, 35, 0, 1, 2, O_MADR);
    add(1, 35, 0, 0, 3, O_MRD);
    add(1, 35, 0, 0, 3, O_MRD);
    add(1, 35, 0, 0, 3, O_MRD);
    add(1, 35, 0, 1, 3, O_MRD);
    add(1, 35, 0, 1, 4, O_MWB);
    // SW
    add(1, 43, 0, 1, 0, O_FR);
    add(1, 43, 0, 1, 1, O_DEC);
    add(1, 43, 0, 1, 2, O_MADR);
    add(1, 43, 0, 1, 5, O_MWR);
    // BEQ
    add(1, 4, 0, 1, 0, O_FR);
    add(1, 4, 0, 1, 1, O_DEC);
    add(1, 4, 0, 1, 10, O_BR);
    // ADDI
    add(1, 8, 0, 1, 0, O_FR);
    add(1, 8, 0, 1, 1, O_DEC);
    add(1, 8, 0, 1, 8, O_EXI_ADD);
    add(1, 8, 0, 1, 9, O_IWB);
    // SLTI
    add(1, 10, 0, 1, 0, O_FR);
    add(1, 10, 0, 1, 1, O_DEC);
    add(1, 10, 0, 1, 8, O_EXI_SLT);
    add(1, 10, 0, 1, 9, O_IWB);
    // NOP: two cycles, not illegal
    add(1, 0, 0, 1, 0, O_FR);
    add(1, 0, 0, 1, 1, O_DEC);
    // opcode 63: single illegal pulse in DECODE
    add(1, 63, 0, 1, 0, O_FR);
    add(1, 63, 0, 1, 1, O_DECI);
    // opcode 2
    add(1, 2, 0, 1, 0, O_FR);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    add(1, 2, 0, 1, 1, O_DEC);
    add(1, 2, 0, 1, 11, O_J);
`else
    add(1, 2, 0, 1, 1, O_DECI);
`endif
    add(1, 0, 0, 0, 0, O_FW);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_i);
      rst_i = vq[i].rst; instr_op_i = vq[i].op;
      instr_funct_i = vq[i].funct; mem_ready_i = vq[i].rdy;
      #1;
      chk("state", i, 32'(state_o), 32'(vq[i].st));
      chk("outputs", i, 32'(get_act()), 32'(vq[i].o));
      chk("rd_wr_excl", i, 32'(mem_read_o & mem_write_o), 32'd0);
    end

    // Reset asserted between edges while in MEMWR
    @(negedge clk_i);
    rst_i = 1'b0; instr_op_i = 6'd43; mem_ready_i = 1'b1;
    #1 chk("rst_state", 100, 32'(state_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("sw_dec", 101, 32'(state_o), 32'd1);
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("sw_madr", 102, 32'(state_o), 32'd2);
    @(negedge clk_i);
    chk("sw_mwr", 103, 32'(state_o), 32'd5);
    chk("sw_mw_on", 103, 32'(mem_write_o), 32'd1);
    @(negedge clk_i);
    chk("sw_mwr_hold", 104, 32'(state_o), 32'd5);
    mem_ready_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_mw", 105, 32'(mem_write_o), 32'd0);
    chk("midrst_state", 105, 32'(state_o), 32'd0);
    chk("midrst_outs", 105, 32'(get_act()), 32'(O_FW));
    // hold reset across an edge: no progress, strobes gated
    @(posedge clk_i); #1;
    chk("rst_hold_state", 106, 32'(state_o), 32'd0);
    chk("rst_hold_outs", 106, 32'(get_act()), 32'(O_FW));
    #2 rst_i = 1'b1;
    #1 chk("rel_outs", 107, 32'(get_act()), 32'(O_FR));
    @(posedge clk_i); #1;
    chk("first_fetch", 108, 32'(state_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALUOP_W, 3: width of alu_op_o; values below 3 are illegal.
REQ-002 Parameter OP_W, 6: width of instr_op_i and instr_funct_i.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 instr_op_i  input  OP_W  opcode field of the instruction register.
REQ-006 instr_funct_i  input  OP_W  funct field of the instruction register.
REQ-007 mem_ready_i  input  1  memory completes current access this cycle.
REQ-008 pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o  output  1 each  PC/IR/memory strobes.
REQ-009 iord_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o  output  1 each  datapath selects/enables.
REQ-010 alu_src_b_o  output  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
REQ-011 pc_src_o  output  2  0=ALU result, 1=ALUOut register, 2=jump target.
REQ-012 alu_op_o  output  ALUOP_W  0=add, 1=sub, 2=funct-decoded, 3=set-less-than; zero-extended.
REQ-013 illegal_o  output  1  one-cycle pulse on unsupported opcode.
REQ-014 state_o  output  4  current state encoding, for debug.

Function
REQ-015 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, RWB 7, EXEC_I 8, IWB 9, BRANCH 10, JUMP 11; 12-15 unreachable, SHALL go to FETCH.
REQ-016 FETCH: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=0; stay while mem_ready_i=0; when mem_ready_i=1, ir_write_o=1 and pc_write_o=1 in that same cycle (Mealy), next DECODE.
REQ-017 DECODE: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=0; next state by opcode: 0 with funct!=0 -> EXEC_R; 0 with funct=0 (NOP) -> FETCH; 8 (ADDI), 10 (SLTI) -> EXEC_I; 35 (LW), 43 (SW) -> MEMADR; 4 (BEQ) -> BRANCH; other -> FETCH with illegal_o=1 this cycle.
REQ-018 MEMADR: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=0; next MEMRD for LW, MEMWR for SW.
REQ-019 MEMRD: mem_read_o=1, iord_o=1; hold until mem_ready_i=1, then MEMWB.
REQ-020 MEMWB: reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0; next FETCH.
REQ-021 MEMWR: mem_write_o=1, iord_o=1; hold until mem_ready_i=1, then FETCH.
REQ-022 EXEC_R: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=2; next RWB. RWB: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0; next FETCH.
REQ-023 EXEC_I: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=0 for ADDI, 3 for SLTI (opcode sampled in EXEC_I); next IWB. IWB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0; next FETCH.
REQ-024 BRANCH: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=1, pc_write_cond_o=1, pc_src_o=1; next FETCH.
REQ-025 Every output not listed for a state SHALL be 0 in that state.
REQ-026 With mem_ready_i held 1, cycles per instruction SHALL be: BEQ/NOP/illegal 3... no: BEQ 3, NOP 2, illegal 2, R-type/ADDI/SLTI/SW 4, LW 5.
REQ-027 mem_read_o and mem_write_o SHALL never be 1 in the same cycle.

Reset
REQ-028 rst_i=0 SHALL immediately, without a clock edge, force state FETCH and all outputs to 0 except FETCH's Moore values, with ir_write_o/pc_write_o held 0 while rst_i=0.
REQ-029 Reset asserted mid-access (MEMRD/MEMWR) SHALL drop mem_write_o the same instant; first fetch starts on the first rising edge after rst_i=1.

Configuration
REQ-030 Macro MULTICYCLE_CTRL_JUMP_EN defined: opcode 2 (J) in DECODE -> JUMP; JUMP: pc_write_o=1, pc_src_o=2; next FETCH (J takes 3 cycles).
REQ-031 Macro undefined: JUMP state absent, opcode 2 treated as illegal per REQ-017, pc_src_o never 2.

Verification
REQ-032 Reset, then ADD (op 0, funct 32), mem_ready_i=1 -> states 0,1,6,7,0; reg_write_o=1 and reg_dst_o=1 only in state 7.
REQ-033 LW (op 35), mem_ready_i=0 for 3 cycles in MEMRD -> state 3 held 4 cycles, then 4 with mem_to_reg_o=1.
REQ-034 BEQ (op 4) -> states 0,1,10,0; pc_write_cond_o=1, alu_op_o=1 only in 10.
REQ-035 Opcode 63 -> illegal_o=1 for exactly one cycle in state 1, no write strobe, return to 0.
REQ-036 rst_i driven 0 mid-MEMWR between edges -> mem_write_o=0 and state_o=0 without clock edge.
REQ-037 Opcode 2 with MULTICYCLE_CTRL_JUMP_EN -> states 0,1,11,0, pc_src_o=2; without macro -> illegal_o pulse.
